// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix streaming stages: default sizes, the loader
// state type and the row/column index width helper.
package matrix_pkg;

   localparam int MATRIX_SIZE_DEFAULT = 3;
   localparam int WORD_LENGTH_DEFAULT = 8;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } loader_state_e;

   // A 1-element range would otherwise give a zero-width index.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col position counter with clear, increment and final-position flag.
module matrix_index_counter
   import matrix_pkg::*;
#(
   parameter int N  = MATRIX_SIZE_DEFAULT,
   parameter int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   input  logic          i_inc,
   output logic [IW-1:0] o_row,
   output logic [IW-1:0] o_col,
   output logic          o_is_final
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [IW-1:0] r_row;
   logic [IW-1:0] r_col;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_inc) begin
         if (r_col == LAST_IDX) begin
            r_col <= '0;
            r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row      = r_row;
   assign o_col      = r_col;
   assign o_is_final = (r_row == LAST_IDX) && (r_col == LAST_IDX);

endmodule

// File: rtl/matrix_stream_loader.sv
// Assembles an N x N matrix from a row-major element stream into a parallel array.
// Define MATRIX_LOADER_DOUBLE_BUFFER_EN to add a separate fill buffer for full throughput.
module matrix_stream_loader
   import matrix_pkg::*;
#(
   parameter int MATRIX_SIZE = MATRIX_SIZE_DEFAULT,
   parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WORD_LENGTH-1:0] in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][WORD_LENGTH-1:0] A,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   frame_error
);

   localparam int IW = idx_width(MATRIX_SIZE);

   loader_state_e r_state;
   logic          r_out_valid;
   logic          r_frame_error;
   logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][WORD_LENGTH-1:0] r_a;

   logic [IW-1:0] w_row;
   logic [IW-1:0] w_col;
   logic          w_is_final;
   logic          w_accept;
   logic          w_xfer;
   logic          w_good_last;
   logic          w_bad_last;

   // Gated by reset so nothing is accepted in the cycle reset is asserted.
   assign in_ready    = (r_state == FILL) && !reset;
   assign w_accept    = in_valid && in_ready;
   assign w_xfer      = r_out_valid && out_ready;
   assign w_good_last = w_accept && in_last && w_is_final;
   assign w_bad_last  = w_accept && (in_last != w_is_final);

   matrix_index_counter #(
      .N  (MATRIX_SIZE),
      .IW (IW)
   ) u_index (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_good_last || w_bad_last),
      .i_inc      (w_accept),
      .o_row      (w_row),
      .o_col      (w_col),
      .o_is_final (w_is_final)
   );

`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
   logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][WORD_LENGTH-1:0] r_fill;
   logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][WORD_LENGTH-1:0] w_fill_next;

   // The last element is merged in so the copy happens on the accepting edge.
   always_comb begin
      w_fill_next               = r_fill;
      w_fill_next[w_row][w_col] = in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= FILL;
         r_out_valid   <= 1'b0;
         r_frame_error <= 1'b0;
         r_a           <= '0;
         r_fill        <= '0;
      end else begin
         r_frame_error <= w_bad_last;
         if (w_xfer) r_out_valid <= 1'b0;
         unique case (r_state)
            FILL: begin
               if (w_accept) r_fill[w_row][w_col] <= in_data;
               if (w_good_last) begin
                  if (!r_out_valid || out_ready) begin
                     r_a         <= w_fill_next;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= FULL;
                  end
               end
            end
            FULL: begin
               if (w_xfer) begin
                  r_a         <= r_fill;
                  r_out_valid <= 1'b1;
                  r_state     <= FILL;
               end
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= FILL;
         r_out_valid   <= 1'b0;
         r_frame_error <= 1'b0;
         r_a           <= '0;
      end else begin
         r_frame_error <= w_bad_last;
         unique case (r_state)
            FILL: begin
               if (w_accept) r_a[w_row][w_col] <= in_data;
               if (w_good_last) begin
                  r_state     <= FULL;
                  r_out_valid <= 1'b1;
               end
            end
            FULL: begin
               if (w_xfer) begin
                  r_state     <= FILL;
                  r_out_valid <= 1'b0;
               end
            end
         endcase
      end
   end
`endif

   assign A           = r_a;
   assign out_valid   = r_out_valid;
   assign frame_error = r_frame_error;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed self-checking bench for matrix_stream_loader (N=3, 8-bit elements).
module tb_matrix_stream_loader;

   localparam int N = 3;
   localparam int W = 8;
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
   localparam logic HOLD_RDY = 1'b1;
`else
   localparam logic HOLD_RDY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [0:N-1][0:N-1][W-1:0] A;
   logic         out_valid;
   logic         out_ready;
   logic         frame_error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   matrix_stream_loader #(
      .MATRIX_SIZE (N),
      .WORD_LENGTH (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .A           (A),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends count elements base, base+1, ... with in_last on element index last_at.
   task automatic stream(input int base, input int count, input int last_at);
      for (int i = 0; i < count; i++) begin
         for (int t = 0; t < 20 && !in_ready; t++) tick();
         check("stream_in_ready", in_ready, 1'b1);
         in_data  = W'(base + i);
         in_valid = 1'b1;
         in_last  = (i == last_at);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int t1;
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_frame_error", frame_error, 1'b0);
      check("rst_a_zero", (A === '0), 1'b1);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);

      // Basic matrix 1..9, downstream always ready.
      out_ready = 1'b1;
      stream(1, 8, -1);
      check("t1_no_valid_early", out_valid, 1'b0);
      stream(9, 1, 0);
      check("t1_out_valid", out_valid, 1'b1);
      check("t1_in_ready_low", in_ready, HOLD_RDY);
      check("t1_a00", A[0][0], 8'd1);
      check("t1_a02", A[0][2], 8'd3);
      check("t1_a11", A[1][1], 8'd5);
      check("t1_a22", A[2][2], 8'd9);
      check("t1_no_err", frame_error, 1'b0);
      tick();
      check("t1_xfer_valid", out_valid, 1'b0);
      check("t1_xfer_ready", in_ready, 1'b1);

      // Backpressure: matrix 11..19 held for 5 cycles.
      out_ready = 1'b0;
      stream(11, 9, 8);
      for (int k = 0; k < 5; k++) begin
         check("t2_hold_ready", in_ready, HOLD_RDY);
         check("t2_hold_valid", out_valid, 1'b1);
         check("t2_hold_a00", A[0][0], 8'd11);
         check("t2_hold_a22", A[2][2], 8'd19);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("t2_xfer_valid", out_valid, 1'b0);
      check("t2_xfer_ready", in_ready, 1'b1);

      // Early in_last on the 4th element.
      stream(21, 4, 3);
      check("t3_err_pulse", frame_error, 1'b1);
      check("t3_err_no_valid", out_valid, 1'b0);
      tick();
      check("t3_err_once", frame_error, 1'b0);
      check("t3_still_no_valid", out_valid, 1'b0);
      stream(10, 9, 8);
      check("t3_out_valid", out_valid, 1'b1);
      check("t3_a00", A[0][0], 8'd10);
      check("t3_a10", A[1][0], 8'd13);
      check("t3_a22", A[2][2], 8'd18);
      tick();

      // Missing in_last on the 9th element.
      stream(31, 9, -1);
      check("t4_err_pulse", frame_error, 1'b1);
      check("t4_err_no_valid", out_valid, 1'b0);
      tick();
      check("t4_err_once", frame_error, 1'b0);
      check("t4_still_no_valid", out_valid, 1'b0);
      stream(41, 9, 8);
      check("t4_out_valid", out_valid, 1'b1);
      check("t4_a00", A[0][0], 8'd41);
      check("t4_a22", A[2][2], 8'd49);
      check("t4_no_err", frame_error, 1'b0);
      tick();

      // Reset after 5 accepted elements.
      stream(51, 5, -1);
      reset = 1'b1;
      tick();
      check("t5_a_zero", (A === '0), 1'b1);
      check("t5_out_valid", out_valid, 1'b0);
      check("t5_in_ready", in_ready, 1'b0);
      reset = 1'b0;
      #1;
      stream(61, 9, 8);
      check("t5_out_valid_after", out_valid, 1'b1);
      check("t5_a00", A[0][0], 8'd61);
      check("t5_a01", A[0][1], 8'd62);
      check("t5_a22", A[2][2], 8'd69);
      tick();

`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
      // Back-to-back matrices with no gap between streams.
      stream(1, 9, 8);
      check("db_first_valid", out_valid, 1'b1);
      check("db_ready_kept", in_ready, 1'b1);
      t1 = cyc;
      stream(10, 9, 8);
      check("db_second_valid", out_valid, 1'b1);
      check("db_second_a00", A[0][0], 8'd10);
      check("db_gap", 64'(cyc - t1), 64'd9);
      tick();
`else
      t1 = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
